// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// if_pkg : shared constants and entry type for the IF prefetch stage
// Rev 1.0
// ============================================================================
package if_pkg;

  localparam logic [31:0] DEFAULT_START_ADDR = 32'hBFC00000;
  localparam int          JBR_BUS_W          = 33;
  localparam int          EXC_BUS_W          = 34;
  localparam int          IF_ID_W            = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// if_fifo : synchronous FIFO of fetched {pc, inst} entries, flush beats push
// Rev 1.0
// ============================================================================
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  if_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output if_entry_t              head
);

  localparam int PW = $clog2(DEPTH);

  if_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_push = push && !flush;
  assign w_do_pop  = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (resetn && w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// if_prefetch : credit-based sequential fetch into a prefetch queue for ID
// Rev 1.0
// ============================================================================
module if_prefetch
  import if_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
  parameter int          DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   inst_req,
  output logic [31:0]            inst_addr,
  input  logic [31:0]            inst,
  input  logic [JBR_BUS_W-1:0]   jbr_bus,
  input  logic [EXC_BUS_W-1:0]   exc_bus,
  input  logic                   id_ready,
  output logic                   if_valid,
  output logic [IF_ID_W-1:0]     IF_ID_bus,
  output logic [31:0]            IF_pc,
  output logic [31:0]            IF_inst,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_req_pc;
  logic         r_inflight;
  logic         r_kill;

  logic         w_exc_valid;
  logic [31:0]  w_exc_pc;
  logic         w_jbr_taken;
  logic [31:0]  w_jbr_target;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_push;
  logic         w_pop;
  logic [CW-1:0] w_count;
  logic [CW:0]  w_credit;
  if_entry_t    w_push_data;
  if_entry_t    w_head;
  logic         w_unused_overflow;

  assign w_exc_valid       = exc_bus[33];
  assign w_exc_pc          = exc_bus[32:1];
  assign w_unused_overflow = exc_bus[0];
  assign w_jbr_taken       = jbr_bus[32];
  assign w_jbr_target      = jbr_bus[31:0];

  assign w_redirect = w_exc_valid | w_jbr_taken;
  assign w_target   = w_exc_valid ? w_exc_pc : w_jbr_target;

  // Queue slots plus the outstanding read must fit, so a response always lands.
  assign w_credit  = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign inst_req  = resetn && !w_redirect && (w_credit < (CW+1)'(DEPTH));
  assign inst_addr = r_fetch_pc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetch_pc <= START_ADDR;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= inst_req;
      r_kill     <= w_redirect && inst_req;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
      end else if (inst_req) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= {r_fetch_pc[31:2] + 30'd1, r_fetch_pc[1:0]};
      end
    end
  end

  assign w_push      = r_inflight && !r_kill && !w_redirect;
  assign w_pop       = if_valid && id_ready;
  assign w_push_data = '{pc: r_req_pc, inst: inst};

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (w_redirect),
    .count     (w_count),
    .head      (w_head)
  );

  assign if_valid  = (w_count != '0);
  assign occupancy = w_count;
  assign IF_ID_bus = w_head;
  assign IF_pc     = w_head.pc;
  assign IF_inst   = w_head.inst;

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// tb_if_prefetch : queue-level reference model plus directed timing checks
// Rev 1.0
// ============================================================================
module tb_if_prefetch;
  import if_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'hBFC00000;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   inst_req;
  logic [31:0]            inst_addr;
  logic [31:0]            inst;
  logic [32:0]            jbr_bus;
  logic [33:0]            exc_bus;
  logic                   id_ready;
  logic                   if_valid;
  logic [63:0]            IF_ID_bus;
  logic [31:0]            IF_pc;
  logic [31:0]            IF_inst;
  logic [$clog2(DEPTH):0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  if_prefetch #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst      (inst),
    .jbr_bus   (jbr_bus),
    .exc_bus   (exc_bus),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .IF_ID_bus (IF_ID_bus),
    .IF_pc     (IF_pc),
    .IF_inst   (IF_inst),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A50F1E;
  endfunction

  // Synchronous ROM; returns noise when not read so stray writes show up.
  always @(posedge clk) inst <= inst_req ? rom(inst_addr) : $urandom;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of pcs waiting for ID, one outstanding read.
  logic [31:0] m_q[$];
  logic        m_inflight;
  logic [31:0] m_req_pc;
  logic [31:0] m_fetch_pc;
  bit          m_live = 0;

  function automatic logic m_redir();
    return exc_bus[33] | jbr_bus[32];
  endfunction

  function automatic logic m_exp_req();
    return resetn && !m_redir() && ((m_q.size() + int'(m_inflight)) < DEPTH);
  endfunction

  task automatic model_step();
    logic req;
    req = m_exp_req();
    if (!resetn) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_fetch_pc = START;
    end else begin
      if (m_q.size() != 0 && id_ready) void'(m_q.pop_front());
      if (m_redir()) begin
        m_q.delete();
        m_fetch_pc = exc_bus[33] ? exc_bus[32:1] : jbr_bus[31:0];
      end else begin
        if (m_inflight) m_q.push_back(m_req_pc);
        if (req) begin
          m_req_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
      m_inflight = req;
    end
  endtask

  task automatic compare();
    chk("inst_req", inst_req, m_exp_req());
    if (m_exp_req()) chk("inst_addr", inst_addr, m_fetch_pc);
    chk("if_valid", if_valid, m_q.size() != 0);
    chk("occupancy", occupancy, m_q.size());
    if (m_q.size() != 0) begin
      chk("IF_ID_bus", IF_ID_bus, {m_q[0], rom(m_q[0])});
      chk("IF_pc", IF_pc, m_q[0]);
      chk("IF_inst", IF_inst, rom(m_q[0]));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      m_live = 1;
      @(negedge clk);
      compare();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    resetn = 1'b0; id_ready = 1'b1; jbr_bus = '0; exc_bus = '0;
    repeat (3) cyc();

    // Reset release: one issue per cycle, first valid two cycles later.
    resetn = 1'b1;
    neg(); chk("t0_req", inst_req, 1); chk("t0_addr", inst_addr, START); chk("t0_valid", if_valid, 0);
    cyc(); neg(); chk("t1_addr", inst_addr, START + 32'd4); chk("t1_valid", if_valid, 0);
    cyc(); neg(); chk("t2_valid", if_valid, 1); chk("t2_pc", IF_pc, START); chk("t2_inst", IF_inst, rom(START));
    repeat (5) cyc();
    neg(); chk("t7_pc", IF_pc, START + 32'd20);

    // Stall: queue saturates, fetch stops, then drains without gaps.
    cyc(); id_ready = 1'b0;
    repeat (9) cyc();
    neg(); chk("stall_occ", occupancy, DEPTH); chk("stall_req", inst_req, 0);
    cyc(); id_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      neg(); chk("drain_valid", if_valid, 1);
      cyc();
    end

    // Branch with a read in flight.
    repeat (3) cyc();
    jbr_bus = {1'b1, 32'hBFC00100};
    neg(); chk("jbr_req", inst_req, 0);
    cyc(); jbr_bus = '0;
    neg(); chk("jbr_t1_addr", inst_addr, 32'hBFC00100); chk("jbr_t1_valid", if_valid, 0);
    cyc(); neg(); chk("jbr_t2_valid", if_valid, 0);
    cyc(); neg(); chk("jbr_t3_valid", if_valid, 1); chk("jbr_t3_pc", IF_pc, 32'hBFC00100);

    // Exception beats a simultaneous branch.
    cyc();
    exc_bus = {1'b1, 32'hBFC00380, 1'b0};
    jbr_bus = {1'b1, 32'hBFC00100};
    cyc(); exc_bus = '0; jbr_bus = '0;
    neg(); chk("exc_req", inst_req, 1); chk("exc_addr", inst_addr, 32'hBFC00380);

    // Pop and redirect together with three entries queued.
    cyc(); id_ready = 1'b0;
    for (int i = 0; i < 20 && occupancy != 3; i++) cyc();
    chk("fill3_occ", occupancy, 3);
    id_ready = 1'b1;
    jbr_bus  = {1'b1, 32'hBFC00200};
    cyc(); jbr_bus = '0;
    neg(); chk("popflush_occ", occupancy, 0); chk("popflush_valid", if_valid, 0);

    // Address wrap at the top of the space.
    cyc();
    jbr_bus = {1'b1, 32'hFFFFFFF8};
    cyc(); jbr_bus = '0;
    cyc(); cyc();
    neg(); chk("wrap_pc0", IF_pc, 32'hFFFFFFF8);
    cyc(); neg(); chk("wrap_pc1", IF_pc, 32'hFFFFFFFC);
    cyc(); neg(); chk("wrap_pc2", IF_pc, 32'h00000000);

    // Reset with a full queue.
    cyc(); id_ready = 1'b0;
    repeat (10) cyc();
    chk("full_occ", occupancy, DEPTH);
    resetn = 1'b0;
    neg(); chk("rst_req0", inst_req, 0);
    cyc(); neg();
    chk("rst_req1", inst_req, 0); chk("rst_valid", if_valid, 0); chk("rst_occ", occupancy, 0);
    cyc(); resetn = 1'b1;
    neg(); chk("rst_rel_req", inst_req, 1); chk("rst_rel_addr", inst_addr, START);

    // Randomized traffic.
    id_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      resetn   = ($urandom_range(0, 199) != 0);
      id_ready = ($urandom_range(0, 9) < 7);
      tgt      = $urandom;
      if ($urandom_range(0, 3) == 0) tgt[31:6] = '1;
      tgt[1:0] = 2'b00;
      jbr_bus  = {($urandom_range(0, 24) == 0), tgt};
      tgt      = $urandom;
      tgt[1:0] = 2'b00;
      exc_bus  = {($urandom_range(0, 49) == 0), tgt, 1'($urandom)};
    end
    cyc();
    jbr_bus = '0; exc_bus = '0; resetn = 1'b1;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
